// File: rtl/fsb_loopback_array.sv
// Multi-channel FSB loopback node: per-channel FIFO with LOOP / INV / GEN / SINK modes.
// Define FSB_LOOPBACK_STATS_EN to build the live rx/tx statistics counters.
module fsb_loopback_array #(
    parameter int                 num_ch_p    = 10,
    parameter int                 width_p     = 80,
    parameter int                 els_p       = 4,
    parameter logic [width_p-1:0] mask_p      = {width_p{1'b1}},
    parameter int                 cnt_width_p = 16
) (
    input  logic                            clk,
    input  logic                            pipe_rst_n,
    input  logic                            en_i,
    input  logic [2*num_ch_p-1:0]           mode_i,
    input  logic [num_ch_p-1:0]             v_i,
    input  logic [width_p*num_ch_p-1:0]     data_i,
    output logic [num_ch_p-1:0]             ready_o,
    output logic [num_ch_p-1:0]             v_o,
    output logic [width_p*num_ch_p-1:0]     data_o,
    input  logic [num_ch_p-1:0]             yumi_i,
    output logic [2*num_ch_p-1:0]           mode_o,
    output logic [cnt_width_p*num_ch_p-1:0] rx_cnt_o,
    output logic [cnt_width_p*num_ch_p-1:0] tx_cnt_o
);
    localparam int lg_els_lp = $clog2(els_p);

    localparam logic [1:0] mode_loop_lp = 2'd0;
    localparam logic [1:0] mode_inv_lp  = 2'd1;
    localparam logic [1:0] mode_gen_lp  = 2'd2;
    localparam logic [1:0] mode_sink_lp = 2'd3;

    localparam logic [lg_els_lp:0]   ptr_one_lp = 1;
    localparam logic [cnt_width_p-1:0] cnt_one_lp = 1;

    for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
        logic [1:0]             mode_q, mode_d;
        logic [lg_els_lp:0]     wptr_q, wptr_d, rptr_q, rptr_d;
        logic [cnt_width_p-1:0] gen_cnt_q, gen_cnt_d;
        logic [width_p-1:0]     mem_q [els_p];
        logic [1:0]             mode_req;
        logic [width_p-1:0]     din, gen_word, dout;
        logic empty, full, fifo_mode, mode_pend;
        logic ready, valid, in_xfer, out_xfer, enq, deq;

        assign mode_req  = mode_i[2*c +: 2];
        assign empty     = (wptr_q == rptr_q);
        assign full      = (wptr_q[lg_els_lp] != rptr_q[lg_els_lp]) &&
                           (wptr_q[lg_els_lp-1:0] == rptr_q[lg_els_lp-1:0]);
        assign fifo_mode = (mode_q == mode_loop_lp) || (mode_q == mode_inv_lp);
        assign mode_pend = (mode_req != mode_q);

        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        always_comb begin
            gen_word = '0;
            gen_word[width_p-1 -: 8]    = 8'(c);
            gen_word[cnt_width_p-1:0]   = gen_cnt_q;
        end

        // Outputs are forced low while reset is held; a pending mode change blocks new input
        // until the switch lands, which keeps the FIFO from refilling under the old mode.
        always_comb begin
            ready = 1'b0;
            valid = 1'b0;
            dout  = '0;
            if (pipe_rst_n) begin
                case (mode_q)
                    mode_loop_lp, mode_inv_lp: begin
                        ready = en_i & ~full & ~mode_pend;
                        valid = ~empty;
                        if (!empty) dout = mem_q[rptr_q[lg_els_lp-1:0]];
                    end
                    mode_gen_lp: begin
                        valid = en_i;
                        if (en_i) dout = gen_word;
                    end
                    default: ready = en_i & ~mode_pend;
                endcase
            end
        end

        always_comb begin
            in_xfer   = v_i[c] & ready;
            out_xfer  = valid & yumi_i[c];
            enq       = in_xfer & fifo_mode;
            deq       = out_xfer & fifo_mode;
            din       = ((mode_q == mode_inv_lp) ? ~data_i[width_p*c +: width_p]
                                                 :  data_i[width_p*c +: width_p]) & mask_p;
            wptr_d    = enq ? wptr_q + ptr_one_lp : wptr_q;
            rptr_d    = deq ? rptr_q + ptr_one_lp : rptr_q;
            gen_cnt_d = (out_xfer && mode_q == mode_gen_lp) ? gen_cnt_q + cnt_one_lp : gen_cnt_q;
            mode_d    = empty ? mode_req : mode_q;
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge pipe_rst_n) begin
            if (!pipe_rst_n) begin
                mode_q    <= mode_loop_lp;
                wptr_q    <= '0;
                rptr_q    <= '0;
                gen_cnt_q <= '0;
            end else begin
                mode_q    <= mode_d;
                wptr_q    <= wptr_d;
                rptr_q    <= rptr_d;
                gen_cnt_q <= gen_cnt_d;
            end
        end

        // NOTE: the storage array is not reset; the pointers alone decide which entries are live.
        always_ff @(posedge clk) begin
            if (enq) mem_q[wptr_q[lg_els_lp-1:0]] <= din;
        end

        assign ready_o[c]                     = ready;
        assign v_o[c]                         = valid;
        assign data_o[width_p*c +: width_p]   = dout;
        assign mode_o[2*c +: 2]               = mode_q;

`ifdef FSB_LOOPBACK_STATS_EN
        logic [cnt_width_p-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

        always_comb begin
            rx_cnt_d = in_xfer  ? rx_cnt_q + cnt_one_lp : rx_cnt_q;
            tx_cnt_d = out_xfer ? tx_cnt_q + cnt_one_lp : tx_cnt_q;
        end

        always_ff @(posedge clk or negedge pipe_rst_n) begin
            if (!pipe_rst_n) begin
                rx_cnt_q <= '0;
                tx_cnt_q <= '0;
            end else begin
                rx_cnt_q <= rx_cnt_d;
                tx_cnt_q <= tx_cnt_d;
            end
        end

        assign rx_cnt_o[cnt_width_p*c +: cnt_width_p] = rx_cnt_q;
        assign tx_cnt_o[cnt_width_p*c +: cnt_width_p] = tx_cnt_q;
`else
        assign rx_cnt_o[cnt_width_p*c +: cnt_width_p] = '0;
        assign tx_cnt_o[cnt_width_p*c +: cnt_width_p] = '0;
`endif
    end

endmodule

// File: tb/tb_fsb_loopback_array.sv
// Self-checking bench for fsb_loopback_array: directed tables and sequences plus random traffic
// compared against a queue-based reference model.
module tb_fsb_loopback_array;
    localparam int NCH  = 10;
    localparam int W    = 80;
    localparam int ELS  = 4;
    localparam int CW   = 16;
    localparam logic [W-1:0] MASK = {8'h00, {72{1'b1}}};
`ifdef FSB_LOOPBACK_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    logic              clk;
    logic              pipe_rst_n;
    logic              en_i;
    logic [2*NCH-1:0]  mode_i;
    logic [NCH-1:0]    v_i;
    logic [W*NCH-1:0]  data_i;
    logic [NCH-1:0]    ready_o;
    logic [NCH-1:0]    v_o;
    logic [W*NCH-1:0]  data_o;
    logic [NCH-1:0]    yumi_i;
    logic [2*NCH-1:0]  mode_o;
    logic [CW*NCH-1:0] rx_cnt_o;
    logic [CW*NCH-1:0] tx_cnt_o;

    // Small single-channel instance with 4-bit counters for wrap tests.
    logic [1:0]   s_mode_i, s_mode_o;
    logic [0:0]   s_v_i, s_ready_o, s_v_o, s_yumi_i;
    logic [W-1:0] s_data_i, s_data_o;
    logic [3:0]   s_rx_cnt_o, s_tx_cnt_o;

    fsb_loopback_array #(
        .num_ch_p(NCH), .width_p(W), .els_p(ELS), .mask_p(MASK), .cnt_width_p(CW)
    ) dut (
        .clk(clk), .pipe_rst_n(pipe_rst_n), .en_i(en_i), .mode_i(mode_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
        .yumi_i(yumi_i), .mode_o(mode_o), .rx_cnt_o(rx_cnt_o), .tx_cnt_o(tx_cnt_o)
    );

    fsb_loopback_array #(
        .num_ch_p(1), .width_p(W), .els_p(2), .cnt_width_p(4)
    ) dut_s (
        .clk(clk), .pipe_rst_n(pipe_rst_n), .en_i(en_i), .mode_i(s_mode_i),
        .v_i(s_v_i), .data_i(s_data_i), .ready_o(s_ready_o), .v_o(s_v_o), .data_o(s_data_o),
        .yumi_i(s_yumi_i), .mode_o(s_mode_o), .rx_cnt_o(s_rx_cnt_o), .tx_cnt_o(s_tx_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks;
    int failures;

    task automatic check(input string name, input int ch, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch=%0d got=%h expected=%h", name, ch, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_fifo [NCH][$];
    int           m_mode [NCH];
    int           m_gen  [NCH];
    int           m_rx   [NCH];
    int           m_tx   [NCH];
    bit           e_ready[NCH];
    bit           e_v    [NCH];
    logic [W-1:0] e_data [NCH];

    function automatic logic [W-1:0] gen_word(input int ch, input int g);
        logic [W-1:0] w;
        w = '0;
        w[W-1 -: 8] = ch[7:0];
        w[CW-1:0]   = g[CW-1:0];
        return w;
    endfunction

    function automatic logic [W-1:0] exp_cnt(input int n);
        return stats_en ? W'(n % (1 << CW)) : '0;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NCH; c++) begin
            m_fifo[c].delete();
            m_mode[c] = 0;
            m_gen[c]  = 0;
            m_rx[c]   = 0;
            m_tx[c]   = 0;
        end
    endtask

    // Outputs follow from the mode rules: a mode switch waits for an empty FIFO, and input is
    // held off while the requested mode differs from the active one.
    task automatic eval_model();
        for (int c = 0; c < NCH; c++) begin
            int req;
            req        = int'(mode_i[2*c +: 2]);
            e_ready[c] = 1'b0;
            e_v[c]     = 1'b0;
            e_data[c]  = '0;
            if (!pipe_rst_n) continue;
            case (m_mode[c])
                0, 1: begin
                    e_v[c]     = m_fifo[c].size() > 0;
                    if (e_v[c]) e_data[c] = m_fifo[c][0];
                    e_ready[c] = en_i && (m_fifo[c].size() < ELS) && (req == m_mode[c]);
                end
                2: begin
                    e_v[c] = en_i;
                    if (en_i) e_data[c] = gen_word(c, m_gen[c]);
                end
                default: e_ready[c] = en_i && (req == m_mode[c]);
            endcase
        end
    endtask

    task automatic update_model();
        for (int c = 0; c < NCH; c++) begin
            bit           was_empty, in_x, out_x;
            logic [W-1:0] d;
            was_empty = (m_fifo[c].size() == 0);
            in_x      = v_i[c] && e_ready[c];
            out_x     = e_v[c] && yumi_i[c];
            d         = data_i[W*c +: W];
            if (in_x && m_mode[c] <= 1) m_fifo[c].push_back(((m_mode[c] == 1) ? ~d : d) & MASK);
            if (out_x && m_mode[c] <= 1) void'(m_fifo[c].pop_front());
            if (out_x && m_mode[c] == 2) m_gen[c] = (m_gen[c] + 1) % (1 << CW);
            if (in_x)  m_rx[c]++;
            if (out_x) m_tx[c]++;
            if (was_empty) m_mode[c] = int'(mode_i[2*c +: 2]);
        end
    endtask

    task automatic compare_model();
        for (int c = 0; c < NCH; c++) begin
            check("ready",      c, W'(ready_o[c]),        W'(e_ready[c]));
            check("valid",      c, W'(v_o[c]),            W'(e_v[c]));
            check("data",       c, data_o[W*c +: W],      e_data[c]);
            check("mode",       c, W'(mode_o[2*c +: 2]),  W'(m_mode[c]));
            check("rx_cnt",     c, W'(rx_cnt_o[CW*c +: CW]), exp_cnt(m_rx[c]));
            check("tx_cnt",     c, W'(tx_cnt_o[CW*c +: CW]), exp_cnt(m_tx[c]));
            check("yumi_legal", c, W'(yumi_i[c] & ~v_o[c]), '0);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
    task automatic cyc();
        #4;
        eval_model();
        compare_model();
    endtask

    task automatic advance();
        eval_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    typedef struct {
        bit           v;
        bit           y;
        logic [W-1:0] d;
        bit           e_rdy;
        bit           e_v;
        logic [W-1:0] e_d;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [W-1:0] gexp;
        logic [95:0]  r;

        checks   = 0;
        failures = 0;

        // LOOP on channel 0: fill to full, drain, then simultaneous enqueue/dequeue.
        tbl[0]  = '{1'b1, 1'b0, 80'h1234, 1'b1, 1'b0, 80'h0};
        tbl[1]  = '{1'b1, 1'b0, 80'h2,    1'b1, 1'b1, 80'h1234};
        tbl[2]  = '{1'b1, 1'b0, 80'h3,    1'b1, 1'b1, 80'h1234};
        tbl[3]  = '{1'b1, 1'b0, 80'h4,    1'b1, 1'b1, 80'h1234};
        tbl[4]  = '{1'b1, 1'b0, 80'h5,    1'b0, 1'b1, 80'h1234};
        tbl[5]  = '{1'b0, 1'b1, 80'h0,    1'b0, 1'b1, 80'h1234};
        tbl[6]  = '{1'b0, 1'b0, 80'h0,    1'b1, 1'b1, 80'h2};
        tbl[7]  = '{1'b0, 1'b1, 80'h0,    1'b1, 1'b1, 80'h2};
        tbl[8]  = '{1'b0, 1'b1, 80'h0,    1'b1, 1'b1, 80'h3};
        tbl[9]  = '{1'b0, 1'b1, 80'h0,    1'b1, 1'b1, 80'h4};
        tbl[10] = '{1'b0, 1'b0, 80'h0,    1'b1, 1'b0, 80'h0};
        tbl[11] = '{1'b1, 1'b0, 80'hAA,   1'b1, 1'b0, 80'h0};
        tbl[12] = '{1'b1, 1'b1, 80'hBB,   1'b1, 1'b1, 80'hAA};
        tbl[13] = '{1'b0, 1'b1, 80'h0,    1'b1, 1'b1, 80'hBB};
        tbl[14] = '{1'b0, 1'b0, 80'h0,    1'b1, 1'b0, 80'h0};

        // Reset with enable and valid driven high: every output must still be 0.
        pipe_rst_n = 1'b0;
        en_i       = 1'b1;
        mode_i     = '0;
        v_i        = '1;
        data_i     = '1;
        yumi_i     = '0;
        s_mode_i   = 2'd0;
        s_v_i      = 1'b1;
        s_data_i   = '1;
        s_yumi_i   = 1'b0;
        reset_model();
        #3;
        eval_model();
        compare_model();
        check("rst_s_ready", 0, W'(s_ready_o), '0);
        check("rst_s_valid", 0, W'(s_v_o), '0);
        #19;
        pipe_rst_n = 1'b1;
        v_i        = '0;
        data_i     = '0;
        s_v_i      = 1'b0;
        s_data_i   = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            v_i[0]        = tbl[i].v;
            yumi_i[0]     = tbl[i].y;
            data_i[W-1:0] = tbl[i].d;
            cyc();
            check("tbl_ready", 0, W'(ready_o[0]), W'(tbl[i].e_rdy));
            check("tbl_valid", 0, W'(v_o[0]),     W'(tbl[i].e_v));
            check("tbl_data",  0, data_o[W-1:0],  tbl[i].e_d);
            advance();
        end
        v_i    = '0;
        yumi_i = '0;

        // INV on channel 3 with the top byte masked off.
        mode_i[7:6] = 2'd1;
        cyc();
        check("inv_pend_ready", 3, W'(ready_o[3]), '0);
        advance();
        v_i[3]          = 1'b1;
        data_i[3*W +: W] = '0;
        cyc();
        check("inv_mode",  3, W'(mode_o[7:6]), W'(2'd1));
        check("inv_ready", 3, W'(ready_o[3]),  W'(1'b1));
        advance();
        v_i[3]    = 1'b0;
        yumi_i[3] = 1'b1;
        cyc();
        check("inv_valid", 3, W'(v_o[3]),       W'(1'b1));
        check("inv_data",  3, data_o[3*W +: W], 80'h00FF_FFFF_FFFF_FFFF_FFFF);
        advance();
        yumi_i[3] = 1'b0;

        // GEN on channel 2 with yumi held for five cycles.
        mode_i[5:4] = 2'd2;
        cyc();
        advance();
        for (int i = 0; i < 5; i++) begin
            yumi_i[2] = 1'b1;
            cyc();
            gexp        = '0;
            gexp[79:72] = 8'h02;
            gexp[15:0]  = 16'(i);
            check("gen_data", 2, data_o[2*W +: W], gexp);
            advance();
        end
        yumi_i[2] = 1'b0;

        // Channel 1: two entries buffered, then LOOP -> SINK.
        v_i[1] = 1'b1;
        data_i[W +: W] = 80'h11;
        cyc(); advance();
        data_i[W +: W] = 80'h22;
        cyc(); advance();
        mode_i[3:2]    = 2'd3;
        data_i[W +: W] = 80'h33;
        cyc();
        check("drain_ready0", 1, W'(ready_o[1]), '0);
        advance();
        v_i[1]    = 1'b0;
        yumi_i[1] = 1'b1;
        cyc();
        check("drain_ready1", 1, W'(ready_o[1]), '0);
        check("drain_data1",  1, data_o[W +: W], 80'h11);
        advance();
        cyc();
        check("drain_ready2", 1, W'(ready_o[1]), '0);
        check("drain_data2",  1, data_o[W +: W], 80'h22);
        advance();
        yumi_i[1] = 1'b0;
        cyc();
        check("drain_empty_v",    1, W'(v_o[1]),      '0);
        check("drain_empty_mode", 1, W'(mode_o[3:2]), W'(2'd0));
        advance();
        v_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("sink_mode",  1, W'(mode_o[3:2]), W'(2'd3));
            check("sink_ready", 1, W'(ready_o[1]),  W'(1'b1));
            check("sink_valid", 1, W'(v_o[1]),      '0);
            advance();
        end
        v_i[1] = 1'b0;
        cyc();
        check("sink_rx_cnt", 1, W'(rx_cnt_o[CW +: CW]), stats_en ? W'(5) : '0);
        advance();

        // 4-bit counters: 17 sink transfers, then 17 generator yumis.
        s_mode_i = 2'd3;
        cyc(); advance();
        s_v_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cyc();
            check("s_sink_ready", 0, W'(s_ready_o), W'(1'b1));
            check("s_sink_valid", 0, W'(s_v_o), '0);
            check("s_rx_running", 0, W'(s_rx_cnt_o), stats_en ? W'(k % 16) : '0);
            advance();
        end
        s_v_i = 1'b0;
        cyc();
        check("s_rx_wrap", 0, W'(s_rx_cnt_o), stats_en ? W'(1) : '0);
        s_mode_i = 2'd2;
        advance();
        cyc(); advance();
        for (int k = 0; k < 17; k++) begin
            s_yumi_i = 1'b1;
            cyc();
            check("s_gen_low",  0, W'(s_data_o[3:0]),   W'(k % 16));
            check("s_gen_chan", 0, W'(s_data_o[79:72]), '0);
            advance();
        end
        s_yumi_i = 1'b0;
        cyc();
        check("s_gen_wrap", 0, W'(s_data_o[3:0]), W'(1));
        check("s_tx_wrap",  0, W'(s_tx_cnt_o), stats_en ? W'(1) : '0);
        advance();

        // Reset asserted mid-burst with three entries buffered on channel 0.
        v_i[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_i[W-1:0] = W'(32'hA1 + k);
            cyc(); advance();
        end
        #2;
        pipe_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 0, W'(|ready_o), '0);
        check("mid_rst_valid", 0, W'(|v_o), '0);
        check("mid_rst_data",  0, W'(|data_o), '0);
        check("mid_rst_mode",  0, W'(|mode_o), '0);
        reset_model();
        mode_i   = '0;
        v_i      = '0;
        yumi_i   = '0;
        s_mode_i = 2'd0;
        @(posedge clk);
        #1;
        check("rst_edge_ready", 0, W'(|ready_o), '0);
        check("rst_edge_valid", 0, W'(|v_o), '0);
        @(negedge clk);
        pipe_rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        check("post_rst_valid", 0, W'(v_o[0]), '0);
        check("post_rst_mode",  0, W'(|mode_o), '0);
        check("post_rst_cnt",   0, W'(|{rx_cnt_o, tx_cnt_o}), '0);
        advance();

        // Random traffic on all channels against the model.
        for (int n = 0; n < 2500; n++) begin
            en_i = ($urandom_range(9) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(63) == 0) mode_i[2*c +: 2] = 2'($urandom_range(3));
                v_i[c] = 1'($urandom_range(1));
                r = {$urandom, $urandom, $urandom};
                data_i[W*c +: W] = r[W-1:0];
            end
            eval_model();
            for (int c = 0; c < NCH; c++) yumi_i[c] = e_v[c] && ($urandom_range(3) != 0);
            cyc();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
